// File: rtl/reg_32s_pkg.sv
// rtl/reg_32s_pkg.sv - shared defaults for the stallable pipeline registers
package reg_32s_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VAL = '0;

endpackage

// File: rtl/reg_32s.sv
// rtl/reg_32s.sv - stallable pipeline register, optional Flush via REG_32S_FLUSH_EN
// Priority per edge: Reset > Flush (if REG_32S_FLUSH_EN) > Stall > load D.
module reg_32s
  import reg_32s_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = DEFAULT_RESET_VAL[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             Reset,
`ifdef REG_32S_FLUSH_EN
  input  logic             Flush,
`endif
  input  logic [WIDTH-1:0] D,
  input  logic             Stall,
  output logic [WIDTH-1:0] Q
);

  // Ternaries rather than if/else so an X control propagates to Q instead of
  // silently selecting the load path in simulation.
  always_ff @(posedge clk) begin
`ifdef REG_32S_FLUSH_EN
    Q <= Reset ? RESET_VAL : (Flush ? RESET_VAL : (Stall ? Q : D));
`else
    Q <= Reset ? RESET_VAL : (Stall ? Q : D);
`endif
  end

endmodule

// File: tb/tb_reg_32s.sv
// tb/tb_reg_32s.sv - directed self-checking bench for reg_32s
module tb_reg_32s;

  logic        clk;
  logic        Reset;
  logic        Stall;
  logic [31:0] D;
  logic [31:0] Q;
`ifdef REG_32S_FLUSH_EN
  logic        Flush;
`endif

  int passed;
  int total;

  reg_32s dut (
    .clk   (clk),
    .Reset (Reset),
`ifdef REG_32S_FLUSH_EN
    .Flush (Flush),
`endif
    .D     (D),
    .Stall (Stall),
    .Q     (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] expected);
    total++;
    assert (Q === expected) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, Q, expected);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    Reset  = 1'b1;
    Stall  = 1'b0;
    D      = 32'h1234_5678;
`ifdef REG_32S_FLUSH_EN
    Flush  = 1'b0;
`endif
    #2;

    step(1);
    check("reset_state", 32'h0);

    // Load: each D held for ten edges, captured one edge after the change
    Reset = 1'b0;
    D = 32'd5;
    step(1);  check("load_5_first", 32'd5);
    step(9);  check("load_5_hold", 32'd5);
    D = 32'd10;
    step(1);  check("load_10_first", 32'd10);
    step(9);  check("load_10_hold", 32'd10);
    D = 32'd20;
    step(1);  check("load_20_first", 32'd20);
    step(9);  check("load_20_hold", 32'd20);

    // Stall holds 20 across ten edges while D shows 1
    Stall = 1'b1;
    D = 32'd1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("stall_hold", 32'd20);
    end

    // Reset held for several edges with D = 2
    Stall = 1'b0;
    Reset = 1'b1;
    D = 32'd2;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("reset_held", 32'h0);
    end
    Reset = 1'b0;
    step(1);  check("reset_release", 32'd2);

    // Reset beats stall
    Stall = 1'b1;
    Reset = 1'b1;
    step(1);  check("reset_over_stall", 32'h0);
    Reset = 1'b0;
    D = 32'd9;
    step(1);  check("stall_after_reset", 32'h0);

    // No catch-up: D values shown during the stall are discarded
    D = 32'd3;
    step(1);  check("stall_ignores_3", 32'h0);
    D = 32'd4;
    step(1);  check("stall_ignores_4", 32'h0);
    Stall = 1'b0;
    D = 32'd6;
    step(1);  check("unstall_takes_current", 32'd6);

    // Mid-cycle glitch on D has no effect if restored before the edge
    D = 32'hDEAD_BEEF;
    #2;
    D = 32'd6;
    step(1);  check("glitch_ignored", 32'd6);

    // Width extremes
    D = 32'hFFFF_FFFF;
    step(1);  check("all_ones", 32'hFFFF_FFFF);
    D = 32'h8000_0001;
    step(1);  check("msb_lsb", 32'h8000_0001);

`ifdef REG_32S_FLUSH_EN
    D = 32'h0000_00AB;
    step(1);  check("flush_pre", 32'h0000_00AB);
    Flush = 1'b1;
    Stall = 1'b1;
    step(1);  check("flush_over_stall", 32'h0);
    Flush = 1'b0;
    Stall = 1'b0;
    D = 32'd7;
    step(1);  check("flush_release", 32'd7);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
